// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the register write sequencer.
package reg_wr_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_HI = 2'd1,
    DATA_LO = 2'd2,
    WRITE   = 2'd3
  } state_e;

  localparam logic [CODE_W-1:0] ERR_SYNC    = 2'b01;
  localparam logic [CODE_W-1:0] ERR_ADDR    = 2'b10;
  localparam logic [CODE_W-1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [3:0] SYNC_DEFAULT = 4'hA;

endpackage

// File: rtl/reg_wr_gap_timer.sv
// Gap counter between bytes of one frame.
//   clock, reset : rising-edge clock, async active-high reset
//   enable       : count this cycle (frame open, no byte accepted)
//   clear        : restart from zero (takes priority over enable)
//   expired      : the count reaches TIMEOUT at the coming edge
module reg_wr_gap_timer
  import reg_wr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [CNT_W-1:0] count_q;

  // Idle-cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Flags the idle cycle that would make the count equal TIMEOUT, so the
  // frame is abandoned on exactly the TIMEOUT-th idle edge.
  assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/reg_write_sequencer.sv
// Byte-serial write-command sequencer feeding the register file.
// Assembles header / data-high / data-low frames and issues one write strobe
// per valid frame; rejects bad sync, out-of-range address and stalled frames.
//   clock, reset   : rising-edge clock, async active-high reset
//   rx_valid_in    : command byte valid
//   rx_data_in     : command byte
//   rx_ready_out   : byte can be accepted (low only in WRITE)
//   r_d_wen_out    : one-cycle register write strobe
//   r_d_waddr_out  : write address, held until next write
//   d_out          : write data, held until next write
//   err_out        : one-cycle error pulse
//   err_code_out   : last error code, held until next error
//   wr_count_out   : successful write count, wraps
//   busy_out       : frame in progress
module reg_write_sequencer
  import reg_wr_pkg::*;
#(
  parameter int unsigned NUM_REGS = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [3:0]  SYNC     = SYNC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid_in,
  input  logic [BYTE_W-1:0] rx_data_in,
  output logic              rx_ready_out,
  output logic              r_d_wen_out,
  output logic [ADDR_W-1:0] r_d_waddr_out,
  output logic [DATA_W-1:0] d_out,
  output logic              err_out,
  output logic [CODE_W-1:0] err_code_out,
  output logic [CNT_W-1:0]  wr_count_out,
  output logic              busy_out
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic                wen_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [DATA_W-1:0]   data_d;
  logic                err_d;
  logic [CODE_W-1:0]   code_d;
  logic [CNT_W-1:0]    cnt_d;

  logic accept;
  logic frame_open;
  logic gap_enable;
  logic gap_clear;
  logic gap_expired;
  logic addr_ok;

  assign rx_ready_out = (state_q != WRITE);
  assign busy_out     = (state_q != IDLE);
  assign accept       = rx_valid_in && rx_ready_out;
  assign frame_open   = (state_q == DATA_HI) || (state_q == DATA_LO);
  assign addr_ok      = (32'(addr_q) < NUM_REGS);

  // Gap timer runs only while waiting for data bytes; cleared on any
  // accept, outside the data states, and on the abandoning edge.
  assign gap_enable = frame_open && !accept;
  assign gap_clear  = !gap_enable || gap_expired;

  reg_wr_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (gap_enable),
    .clear   (gap_clear),
    .expired (gap_expired)
  );

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      hi_q          <= '0;
      r_d_wen_out   <= 1'b0;
      r_d_waddr_out <= '0;
      d_out         <= '0;
      err_out       <= 1'b0;
      err_code_out  <= '0;
      wr_count_out  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      hi_q          <= hi_d;
      r_d_wen_out   <= wen_d;
      r_d_waddr_out <= waddr_d;
      d_out         <= data_d;
      err_out       <= err_d;
      err_code_out  <= code_d;
      wr_count_out  <= cnt_d;
    end
  end

  // Next state and registered-output values. The write decision is made on
  // the edge accepting the low byte so the strobe lands in the WRITE cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    wen_d   = 1'b0;
    waddr_d = r_d_waddr_out;
    data_d  = d_out;
    err_d   = 1'b0;
    code_d  = err_code_out;
    cnt_d   = wr_count_out;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (rx_data_in[7:4] != SYNC) begin
            err_d  = 1'b1;
            code_d = ERR_SYNC;
          end else begin
            addr_d  = rx_data_in[ADDR_W-1:0];
            state_d = DATA_HI;
          end
        end
      end

      DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data_in;
          state_d = DATA_LO;
        end else if (gap_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end

      DATA_LO: begin
        if (accept) begin
          state_d = WRITE;
          if (addr_ok) begin
            wen_d   = 1'b1;
            waddr_d = addr_q;
            data_d  = {hi_q, rx_data_in};
            cnt_d   = wr_count_out + CNT_W'(1);
          end else begin
            err_d  = 1'b1;
            code_d = ERR_ADDR;
          end
        end else if (gap_expired) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end
      end

      WRITE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Scoreboard bench for reg_write_sequencer: stimulus pushes expected write /
// error events, a negedge monitor pops and compares when the DUT strobes.
module tb_reg_write_sequencer;
  import reg_wr_pkg::*;

  logic        clock;
  logic        reset;
  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        rx_ready_out;
  logic        r_d_wen_out;
  logic [2:0]  r_d_waddr_out;
  logic [15:0] d_out;
  logic        err_out;
  logic [1:0]  err_code_out;
  logic [7:0]  wr_count_out;
  logic        busy_out;

  reg_write_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .rx_valid_in   (rx_valid_in),
    .rx_data_in    (rx_data_in),
    .rx_ready_out  (rx_ready_out),
    .r_d_wen_out   (r_d_wen_out),
    .r_d_waddr_out (r_d_waddr_out),
    .d_out         (d_out),
    .err_out       (err_out),
    .err_code_out  (err_code_out),
    .wr_count_out  (wr_count_out),
    .busy_out      (busy_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic        ready;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void push_wr(input logic [2:0] a, input logic [15:0] d, input logic [7:0] c);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.ready = 1'b0;
    e.addr = a; e.data = d; e.cnt = c;
    exp_q.push_back(e);
  endfunction

  function automatic void push_err(input logic [1:0] code, input logic rdy);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.ready = rdy;
    e.addr = 3'd0; e.data = 16'd0; e.cnt = 8'd0;
    exp_q.push_back(e);
  endfunction

  // Monitor: any strobe or error pulse must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && (r_d_wen_out || err_out)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({r_d_wen_out, err_out}), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_err) begin
          check("err_pulse", 32'(err_out), 32'(1));
          check("err_no_wen", 32'(r_d_wen_out), 32'(0));
          check("err_code", 32'(err_code_out), 32'(mon_e.code));
          check("err_ready", 32'(rx_ready_out), 32'(mon_e.ready));
        end else begin
          check("wr_strobe", 32'(r_d_wen_out), 32'(1));
          check("wr_no_err", 32'(err_out), 32'(0));
          check("wr_addr", 32'(r_d_waddr_out), 32'(mon_e.addr));
          check("wr_data", 32'(d_out), 32'(mon_e.data));
          check("wr_count", 32'(wr_count_out), 32'(mon_e.cnt));
          check("wr_ready_low", 32'(rx_ready_out), 32'(0));
        end
      end
    end
  end

  // Present a byte and hold it until accepted; returns #1 after the accept edge.
  task automatic send(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_data_in  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rx_ready_out) begin
        @(posedge clock);
        #1;
        return;
      end
    end
    check("send_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    rx_valid_in = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    rx_valid_in = 1'b0;
    rx_data_in  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_wen", 32'(r_d_wen_out), 32'(0));
    check("rst_waddr", 32'(r_d_waddr_out), 32'(0));
    check("rst_data", 32'(d_out), 32'(0));
    check("rst_err", 32'(err_out), 32'(0));
    check("rst_code", 32'(err_code_out), 32'(0));
    check("rst_count", 32'(wr_count_out), 32'(0));
    check("rst_ready", 32'(rx_ready_out), 32'(1));
    check("rst_busy", 32'(busy_out), 32'(0));
    reset = 1'b0;
    idle(1);

    // Back-to-back frames, valid held high
    push_wr(3'd1, 16'h1234, 8'd1);
    push_wr(3'd0, 16'hBEEF, 8'd2);
    send(8'hA1); send(8'h12); send(8'h34);
    send(8'hA0); send(8'hBE); send(8'hEF);
    idle(2);
    check("b2b_count", 32'(wr_count_out), 32'(2));

    // Bad sync header then a good frame
    push_err(ERR_SYNC, 1'b1);
    send(8'h51);
    check("sync_stays_idle", 32'(busy_out), 32'(0));
    push_wr(3'd1, 16'h55AA, 8'd3);
    send(8'hA1); send(8'h55); send(8'hAA);
    idle(2);

    // Out-of-range address
    push_err(ERR_ADDR, 1'b0);
    send(8'hA5); send(8'h00); send(8'h01);
    idle(2);
    check("addr_count_kept", 32'(wr_count_out), 32'(3));

    // Timeout after 255 idle cycles
    push_err(ERR_TIMEOUT, 1'b1);
    send(8'hA1);
    idle(254);
    check("to_busy_before", 32'(busy_out), 32'(1));
    check("code_held", 32'(err_code_out), 32'(ERR_ADDR));
    idle(1);
    check("to_busy_after", 32'(busy_out), 32'(0));
    check("to_code", 32'(err_code_out), 32'(ERR_TIMEOUT));
    push_wr(3'd0, 16'h0007, 8'd4);
    send(8'hA0); send(8'h00); send(8'h07);
    idle(2);

    // 254-cycle gap before data high: no timeout
    push_wr(3'd0, 16'hC33C, 8'd5);
    send(8'hA0);
    idle(254);
    check("gap254_busy", 32'(busy_out), 32'(1));
    send(8'hC3); send(8'h3C);
    idle(2);

    // Reset in DATA_LO drops the frame silently
    send(8'hA1); send(8'h11);
    check("pre_rst_busy", 32'(busy_out), 32'(1));
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_wen", 32'(r_d_wen_out), 32'(0));
    check("mid_rst_waddr", 32'(r_d_waddr_out), 32'(0));
    check("mid_rst_data", 32'(d_out), 32'(0));
    check("mid_rst_err", 32'(err_out), 32'(0));
    check("mid_rst_code", 32'(err_code_out), 32'(0));
    check("mid_rst_count", 32'(wr_count_out), 32'(0));
    check("mid_rst_busy", 32'(busy_out), 32'(0));
    check("mid_rst_ready", 32'(rx_ready_out), 32'(1));
    rx_valid_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
    push_wr(3'd0, 16'h0001, 8'd1);
    send(8'hA0); send(8'h00); send(8'h01);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_sequencer.md
# reg_write_sequencer

Byte-serial write-command sequencer that sits directly upstream of the register file. It accepts 8-bit command bytes over a valid/ready handshake and assembles three-byte frames (header, data high, data low). For each valid frame it issues a single-cycle write strobe with a 3-bit address and 16-bit data, which connect directly to the register file's write-enable, write-address and write-data inputs. Malformed frames, out-of-range addresses and stalled frames are rejected with an error pulse.

## Interface
- NUM_REGS, 2, number of implemented registers; addresses ≥ NUM_REGS are rejected
- TIMEOUT, 255, maximum idle cycles allowed between bytes of one frame (1..255)
- SYNC, 4'hA, required value of header bits [7:4]

Ports:
- reset  in  1  asynchronous, active-high
- clock  in  1  rising-edge clock
- rx_valid_in  in  1  byte valid
- rx_data_in  in  8  command byte
- rx_ready_out  out  1  sequencer can accept a byte
- r_d_wen_out  out  1  register write strobe, one cycle
- r_d_waddr_out  out  3  write address
- d_out  out  16  write data
- err_out  out  1  error pulse, one cycle
- err_code_out  out  2  error code; 01 = bad sync, 10 = bad address, 11 = timeout; held until next error
- wr_count_out  out  8  count of successful writes; wraps at 255 to 0
- busy_out  out  1  frame in progress (state ≠ IDLE)

## Operation
- States:
  - IDLE: waits for a header byte.
  - DATA_HI: waits for the data high byte.
  - DATA_LO: waits for the data low byte.
  - WRITE: issues the write, lasts one cycle.
- Handshake:
  - A byte is accepted on a rising edge with rx_valid_in & rx_ready_out.
  - rx_ready_out = (state ≠ WRITE); it is combinational from state.
- IDLE, header accepted:
  - If bits [7:4] ≠ SYNC: discard the byte, stay in IDLE, pulse err with code 01.
  - Otherwise: latch addr = bits [2:0] and go to DATA_HI. Bit 3 is ignored.
- DATA_HI, byte accepted: latch data[15:8], go to DATA_LO.
- DATA_LO, byte accepted: latch data[7:0], go to WRITE.
- WRITE:
  - If addr < NUM_REGS: r_d_wen_out = 1 and wr_count increments.
  - Otherwise: no strobe, err pulse with code 10.
  - Always returns to IDLE.
- Timeout:
  - In DATA_HI or DATA_LO, the gap counter increments on every cycle with no accepted byte. It clears on each accept and on entering IDLE.
  - When the counter reaches TIMEOUT: abandon the frame, go to IDLE, err pulse with code 11.
  - An accept in the same cycle as the counter reaching TIMEOUT takes priority (no timeout).
- The gap counter does not run in IDLE.

## Timing
- Reset (async) forces:
  - state = IDLE
  - r_d_wen_out = 0, r_d_waddr_out = 0, d_out = 0
  - err_out = 0, err_code_out = 0, wr_count_out = 0
  - gap counter = 0
- Consequences of reset: rx_ready_out = 1 and busy_out = 0. A reset mid-frame drops the partial frame silently, with no error.
- r_d_wen_out, r_d_waddr_out, d_out, err_out and wr_count_out are registered outputs.
- Write latency:
  - The strobe is high in the cycle immediately after the edge that accepted the data low byte.
  - r_d_waddr_out and d_out are valid in that same cycle and hold until the next write.
- Throughput: 4 cycles per frame minimum (3 accepts plus 1 WRITE cycle in which ready is low).
- Error pulses are one cycle wide:
  - bad sync: the cycle after the accept
  - bad address: the WRITE cycle
  - timeout: the cycle after the counter reaches TIMEOUT
- wr_count_out updates in the same cycle as the strobe.

## Structure
- Package reg_wr_pkg holds:
  - the state enum (IDLE, DATA_HI, DATA_LO, WRITE)
  - error code constants ERR_SYNC = 2'b01, ERR_ADDR = 2'b10, ERR_TIMEOUT = 2'b11
  - the SYNC default
- Sub-module reg_wr_gap_timer is an 8-bit gap counter:
  - inputs: enable, clear
  - output: expired, when count == TIMEOUT
  - same asynchronous reset as the sequencer
- The sequencer top holds the FSM, the data/address latches and the write counter.

## Test plan
- Back-to-back frames 0xA1,0x12,0x34 then 0xA0,0xBE,0xEF with valid held high:
  - strobe to addr 1 with data 0x1234, then addr 0 with data 0xBEEF
  - ready low one cycle after each frame
  - wr_count_out = 2
- Header 0x51: err pulse with code 01, no strobe, state stays IDLE; a following valid frame writes normally.
- Frame 0xA5,0x00,0x01: three bytes consumed, err pulse with code 10 in the WRITE cycle, no strobe, wr_count unchanged.
- Header 0xA1 then valid low for 255 cycles:
  - err pulse with code 11, busy_out drops
  - next byte 0xA0 is treated as a header
- Gap of exactly 254 cycles before the data high byte: no timeout, write completes.
- Assert reset during DATA_LO:
  - all outputs return to 0, busy_out = 0, no strobe, no error
  - a frame after reset release writes correctly
